// File: rtl/avalon_led_pio_fx.sv
// Avalon-MM LED output port with atomic set/clear, per-channel blink and global PWM dimming.
// Zero-wait-state slave; out_port is one register stage behind the DATA register.
module avalon_led_pio_fx #(
    parameter int               WIDTH       = 18,
    parameter int               PRESCALE_W  = 24,
    parameter int               PWM_W       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_BLINK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_DUTY   = 3'd5;

    logic [WIDTH-1:0]      data_out;
    logic [WIDTH-1:0]      blink_mask;
    logic [PRESCALE_W-1:0] period;
    logic [PWM_W-1:0]      duty;
    logic [PRESCALE_W-1:0] cnt;
    logic                  phase;
    logic [PWM_W-1:0]      pwm_cnt;
    logic                  pwm_on;
    logic                  wr_en;
    logic                  period_wr;
    logic                  unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign period_wr    = wr_en && (address == ADDR_PERIOD);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out   <= RESET_VALUE;
            blink_mask <= '0;
            period     <= '0;
            duty       <= '1;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out   <= writedata[WIDTH-1:0];
                ADDR_SET:    data_out   <= data_out | writedata[WIDTH-1:0];
                ADDR_CLR:    data_out   <= data_out & ~writedata[WIDTH-1:0];
                ADDR_BLINK:  blink_mask <= writedata[WIDTH-1:0];
                ADDR_PERIOD: period     <= writedata[PRESCALE_W-1:0];
                ADDR_DUTY:   duty       <= writedata[PWM_W-1:0];
                default: ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle in the on phase, overriding a same-edge toggle.
    always_ff @(posedge clk) begin
        if (!reset_n || period_wr || (period == '0)) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    assign pwm_on = (duty == '1) ? 1'b1 : (pwm_cnt < duty);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= data_out & ~(blink_mask & {WIDTH{~phase}}) & {WIDTH{pwm_on}};
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]      = data_out;
            ADDR_BLINK:  readdata[WIDTH-1:0]      = blink_mask;
            ADDR_PERIOD: readdata[PRESCALE_W-1:0] = period;
            ADDR_DUTY:   readdata[PWM_W-1:0]      = duty;
            default:     readdata                 = '0;
        endcase
    end

endmodule
